spi_cfg_arbiter: RTL
====================

SPI_CFG_ARBITER -- requirements
Module: spi_cfg_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of config-master channels (2..8).
REQ-002 SHALL have parameter MOSI_DATA_WIDTH, default 24, SPI write word width.
REQ-003 SHALL have parameter MISO_DATA_WIDTH, default 9, SPI read word width.
REQ-004 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have parameter GAP_CYCLES, default 4, cycles with all CS high between sessions (1..255).
REQ-006 SHALL have parameter TIMEOUT, default 4096, idle-owner cycles before forced release (16-bit counter).
REQ-007 SHALL have port clk_20m  in  1  clock; all logic on rising edge.
REQ-008 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-009 SHALL have port ch_req  in  NUM_CH  per-channel session request (cfg_go style), held high for the whole session.
REQ-010 SHALL have port ch_wr_cmd / ch_rd_cmd  in  NUM_CH each  per-channel single-cycle command pulses.
REQ-011 SHALL have port ch_wr_data  in  NUM_CH*MOSI_DATA_WIDTH  channel i at bits [i*W +: W].
REQ-012 SHALL have port ch_gnt  out  NUM_CH  one-hot grant, registered.
REQ-013 SHALL have port ch_busy  out  NUM_CH  per-channel busy.
REQ-014 SHALL have port ch_rd_data  out  MISO_DATA_WIDTH  broadcast read data from master.
REQ-015 SHALL have ports m_wr_cmd, m_rd_cmd  out  1; m_wr_data  out  MOSI_DATA_WIDTH; m_busy, m_ncs  in  1; m_rd_data  in  MISO_DATA_WIDTH; to the shared spi_master.
REQ-016 SHALL have port cs_n  out  NUM_CH  per-device chip selects.
REQ-017 SHALL have ports timeout_o  out  1 (one-cycle pulse) and cmd_drop  out  NUM_CH (sticky flags).

Function
REQ-018 SHALL implement states IDLE, GRANT, GAP.
REQ-019 IDLE: when any ch_req is high, SHALL select a winner per ARB_MODE, register ch_gnt, and enter GRANT next cycle.
REQ-020 Round-robin SHALL search from pointer p upward with wrap, and set p = winner+1 mod NUM_CH on each grant; p resets to 0.
REQ-021 GRANT: cs_n[g] SHALL equal m_ncs for granted channel g; all other cs_n bits SHALL be 1.
REQ-022 GRANT: a command from g with ch_req[g]=1 and m_busy=0 SHALL appear on m_wr_cmd/m_rd_cmd exactly 1 cycle later, with m_wr_data registered in the same cycle.
REQ-023 If ch_wr_cmd and ch_rd_cmd are both high, write SHALL be forwarded, read dropped, cmd_drop[g] set.
REQ-024 Commands from non-granted channels, with ch_req low, or while m_busy=1 or a forward is pending SHALL be dropped and cmd_drop[i] set.
REQ-025 ch_busy[i] SHALL be 1 when i is not granted; for g SHALL be m_busy OR forward-pending.
REQ-026 GRANT SHALL exit to GAP when ch_req[g]=0 and m_busy=0 and no forward is pending.
REQ-027 Idle counter SHALL count GRANT cycles with m_busy=0 and no command; cleared on command or m_busy; at TIMEOUT-1 SHALL force GAP and pulse timeout_o.
REQ-028 Entering GAP SHALL clear ch_gnt; all cs_n high for exactly GAP_CYCLES cycles, then IDLE.
REQ-029 Requests arriving during GRANT or GAP SHALL be held off and arbitrated only in IDLE.
REQ-030 ch_rd_data SHALL be m_rd_data passed through combinationally.

Reset
REQ-031 While rstn=0 at a clock edge: state IDLE, ch_gnt=0, cs_n all 1, m_wr_cmd=m_rd_cmd=0, m_wr_data=0, timeout_o=0, cmd_drop=0, counters and p=0.
REQ-032 Reset mid-session SHALL abandon the session immediately; the bench must see cs_n all 1 on the cycle after the reset edge.

Verification
REQ-033 NUM_CH=3, ARB_MODE=1, ch_req=3'b111 held; each owner drops req after one write -> grants 0,1,2,0 in order, >=4 all-high cs_n cycles between sessions.
REQ-034 ARB_MODE=0, ch_req=3'b110 -> ch_gnt=3'b010; ch_wr_cmd[1] with data 0x000A5C -> m_wr_cmd 1 cycle later, m_wr_data=0x000A5C, cs_n[1] tracks m_ncs.
REQ-035 Channel 2 pulses ch_wr_cmd while channel 0 is granted -> no m_wr_cmd, cmd_drop=3'b100.
REQ-036 Granted channel holds ch_req with no commands, TIMEOUT=16 -> timeout_o pulses after 16 idle cycles, ch_gnt=0, GAP entered.
REQ-037 Simultaneous ch_wr_cmd and ch_rd_cmd on owner -> only m_wr_cmd, cmd_drop[g]=1.
REQ-038 rstn low during active transfer -> all REQ-031 values next cycle; new request granted normally after release.

Source files
------------

// File: rtl/spi_cfg_arbiter.sv
// Arbitrates several configuration masters onto one shared SPI master.
// One owner at a time, fixed-priority or round-robin, with a chip-select gap between sessions.
module spi_cfg_arbiter #(
  parameter int NUM_CH          = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 9,
  parameter int ARB_MODE        = 1,
  parameter int GAP_CYCLES      = 4,
  parameter int TIMEOUT         = 4096
) (
  input  logic                              clk_20m,
  input  logic                              rstn,
  input  logic [NUM_CH-1:0]                 ch_req,
  input  logic [NUM_CH-1:0]                 ch_wr_cmd,
  input  logic [NUM_CH-1:0]                 ch_rd_cmd,
  input  logic [NUM_CH*MOSI_DATA_WIDTH-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]                 ch_gnt,
  output logic [NUM_CH-1:0]                 ch_busy,
  output logic [MISO_DATA_WIDTH-1:0]        ch_rd_data,
  output logic                              m_wr_cmd,
  output logic                              m_rd_cmd,
  output logic [MOSI_DATA_WIDTH-1:0]        m_wr_data,
  input  logic                              m_busy,
  input  logic                              m_ncs,
  input  logic [MISO_DATA_WIDTH-1:0]        m_rd_data,
  output logic [NUM_CH-1:0]                 cs_n,
  output logic                              timeout_o,
  output logic [NUM_CH-1:0]                 cmd_drop
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           owner, owner_nxt;
  logic [IDX_W-1:0]           ptr, ptr_nxt;
  logic [NUM_CH-1:0]          gnt_nxt;
  logic [7:0]                 gap_cnt, gap_cnt_nxt;
  logic [15:0]                idle_cnt, idle_cnt_nxt;
  logic                       fwd_wr_nxt, fwd_rd_nxt, timeout_nxt;
  logic [MOSI_DATA_WIDTH-1:0] wr_data_nxt;
  logic [NUM_CH-1:0]          drop_set;
  logic [IDX_W-1:0]           winner;
  logic                       found;

  logic fwd_pending, in_grant, own_req, own_wr, own_rd, own_cmd, accept, owner_done;

  // A forward is in flight during the cycle the command strobe is on the master port.
  assign fwd_pending = m_wr_cmd | m_rd_cmd;
  assign in_grant    = (state == GRANT);
  assign own_req     = ch_req[owner];
  assign own_wr      = ch_wr_cmd[owner];
  assign own_rd      = ch_rd_cmd[owner];
  assign own_cmd     = own_wr | own_rd;
  assign accept      = in_grant && own_req && own_cmd && !m_busy && !fwd_pending;
  assign owner_done  = !own_req && !m_busy && !fwd_pending;

  assign cs_n       = ~ch_gnt | {NUM_CH{m_ncs}};
  assign ch_busy    = ~ch_gnt | {NUM_CH{m_busy | fwd_pending}};
  assign ch_rd_data = m_rd_data;

  // Search starts at ptr in round-robin mode, at channel 0 in fixed-priority mode.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE == 1) ? (int'(ptr) + k) % NUM_CH : k;
      if (!found && ch_req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = ch_gnt;
    owner_nxt    = owner;
    ptr_nxt      = ptr;
    gap_cnt_nxt  = gap_cnt;
    idle_cnt_nxt = idle_cnt;
    fwd_wr_nxt   = 1'b0;
    fwd_rd_nxt   = 1'b0;
    timeout_nxt  = 1'b0;
    wr_data_nxt  = m_wr_data;
    drop_set     = (ch_wr_cmd | ch_rd_cmd) & ~({NUM_CH{accept}} & ch_gnt);
    if (accept && own_wr && own_rd) drop_set = drop_set | ch_gnt;

    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = GRANT;
          gnt_nxt      = NUM_CH'(1) << winner;
          owner_nxt    = winner;
          idle_cnt_nxt = '0;
          if (ARB_MODE == 1)
            ptr_nxt = (winner == IDX_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
        end
      end
      GRANT: begin
        if (accept) begin
          fwd_wr_nxt = own_wr;
          fwd_rd_nxt = !own_wr;
          if (own_wr)
            wr_data_nxt = ch_wr_data[owner*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
        end
        if (m_busy || own_cmd || fwd_pending) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == 16'(TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
        if (owner_done || timeout_nxt) begin
          state_nxt    = GAP;
          gnt_nxt      = '0;
          gap_cnt_nxt  = '0;
          idle_cnt_nxt = '0;
        end
      end
      GAP: begin
        if (gap_cnt == 8'(GAP_CYCLES - 1)) state_nxt = IDLE;
        else                               gap_cnt_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; rstn is deliberately absent from the sensitivity list.
  always_ff @(posedge clk_20m) begin
    if (!rstn) begin
      // NOTE: state registers take non-blocking assignments so every flop sees pre-edge values.
      state     <= IDLE;
      ch_gnt    <= '0;
      owner     <= '0;
      ptr       <= '0;
      gap_cnt   <= '0;
      idle_cnt  <= '0;
      m_wr_cmd  <= 1'b0;
      m_rd_cmd  <= 1'b0;
      m_wr_data <= '0;
      timeout_o <= 1'b0;
      cmd_drop  <= '0;
    end else begin
      state     <= state_nxt;
      ch_gnt    <= gnt_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      gap_cnt   <= gap_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
      m_wr_cmd  <= fwd_wr_nxt;
      m_rd_cmd  <= fwd_rd_nxt;
      m_wr_data <= wr_data_nxt;
      timeout_o <= timeout_nxt;
      cmd_drop  <= cmd_drop | drop_set;
    end
  end

endmodule
